// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and lane/extension helpers for the data memory LSU
package dmem_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } size_e;

    typedef enum logic {
        IDLE     = 1'b0,
        SPLIT_HI = 1'b1
    } state_e;

    // Byte enables across two consecutive words: [3:0] addressed word, [7:4] next word
    function automatic logic [2*WORD_BYTES-1:0] lane_mask(input size_e sz, input logic [1:0] off);
        logic [2*WORD_BYTES-1:0] base;
        case (sz)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] off);
        return (sz == SZ_H && off == 2'd3) || (sz == SZ_W && off != 2'd0);
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] d, input size_e sz, input logic uns);
        logic [31:0] r;
        case (sz)
            SZ_B:    r = {{24{~uns & d[7]}}, d[7:0]};
            SZ_H:    r = {{16{~uns & d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - word RAM with byte write enables and registered read
module dmem_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Read returns the pre-write contents; callers never read and write one word on the same edge
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store port: range/size checks, lane steering, response register
// Optional DMEM_MISALIGN_SPLIT_EN: misaligned accesses split across two words via SPLIT_HI
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    size_e             size;
    logic [ADDR_W-1:0] rel_addr;
    logic [1:0]        off;
    logic [AW-1:0]     widx;
    logic              out_of_range, mis, err, accept;
    logic [7:0]        lanes;
    logic [63:0]       wide;

    logic              bank_en;
    logic [3:0]        bank_be;
    logic [AW-1:0]     bank_addr;
    logic [31:0]       bank_wdata, bank_rdata;

    logic              pend, m_we, m_err, m_uns;
    logic [1:0]        m_off;
    size_e             m_size;
    logic [31:0]       load_data;

    assign size         = size_e'(req_size);
    assign rel_addr     = req_addr - BASE_ADDR;
    assign off          = rel_addr[1:0];
    assign widx         = rel_addr[AW+1:2];
    assign out_of_range = (req_addr < BASE_ADDR) || ((rel_addr >> 2) >= ADDR_W'(DEPTH_WORDS));
    assign mis          = misaligned(size, off);
    assign lanes        = lane_mask(size, off);
    assign wide         = {32'b0, req_wdata} << {off, 3'b000};
    assign accept       = req_valid && req_ready;

`ifdef DMEM_MISALIGN_SPLIT_EN
    state_e        state_q, state_d;
    logic [AW-1:0] hi_idx;
    logic [3:0]    hi_be;
    logic [31:0]   hi_wdata, lo_hold, shifted;
    logic          m_split;
    logic [63:0]   merged;

    // A split whose second word falls off the end is rejected up front so neither word is written
    assign err = (size == SZ_BAD) || out_of_range || (mis && (widx == AW'(DEPTH_WORDS - 1)));

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b1;
        case (state_q)
            IDLE: begin
                if (req_valid && mis) state_d = SPLIT_HI;
            end
            SPLIT_HI: begin
                req_ready = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign merged    = m_split ? {bank_rdata, lo_hold} : {32'b0, bank_rdata};
    assign shifted   = 32'(merged >> {m_off, 3'b000});
    assign load_data = extend(shifted, m_size, m_uns);
`else
    logic unused_split;

    assign err          = (size == SZ_BAD) || out_of_range || mis;
    assign req_ready    = 1'b1;
    assign load_data    = extend(bank_rdata >> {m_off, 3'b000}, m_size, m_uns);
    assign unused_split = ^{lanes[7:4], wide[63:32]};
`endif

    always_comb begin
        bank_en    = accept;
        bank_addr  = widx;
        bank_wdata = wide[31:0];
        bank_be    = (accept && req_we && !err) ? lanes[3:0] : 4'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
        if (state_q == SPLIT_HI) begin
            bank_en    = 1'b1;
            bank_addr  = hi_idx;
            bank_wdata = hi_wdata;
            bank_be    = hi_be;
        end
`endif
    end

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_bank (
        .clk  (clk),
        .en   (bank_en),
        .be   (bank_be),
        .addr (bank_addr),
        .wdata(bank_wdata),
        .rdata(bank_rdata)
    );

    // pend marks that the bank output this cycle completes a request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      <= 1'b0;
            m_we      <= 1'b0;
            m_err     <= 1'b0;
            m_uns     <= 1'b0;
            m_off     <= 2'b0;
            m_size    <= SZ_B;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
`ifdef DMEM_MISALIGN_SPLIT_EN
            m_split   <= 1'b0;
            hi_idx    <= '0;
            hi_be     <= '0;
            hi_wdata  <= '0;
            lo_hold   <= '0;
`endif
        end else begin
            rsp_valid <= pend;
            rsp_err   <= pend && m_err;
            rsp_rdata <= (pend && !m_err && !m_we) ? load_data : '0;
            if (accept) begin
                m_we   <= req_we;
                m_err  <= err;
                m_uns  <= req_unsigned;
                m_off  <= off;
                m_size <= size;
`ifdef DMEM_MISALIGN_SPLIT_EN
                pend     <= !mis;
                m_split  <= mis;
                hi_idx   <= widx + AW'(1);
                hi_be    <= (req_we && !err) ? lanes[7:4] : 4'b0;
                hi_wdata <= wide[63:32];
`else
                pend   <= 1'b1;
`endif
            end
`ifdef DMEM_MISALIGN_SPLIT_EN
            else if (state_q == SPLIT_HI) begin
                pend    <= 1'b1;
                lo_hold <= bank_rdata;
            end
`endif
            else begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - randomized self-checking bench for dmem_lsu against a byte-array model
module tb_dmem_lsu;

    localparam int          ADDR_W = 32;
    localparam int          DEPTH  = 64;
    localparam logic [31:0] BASE   = 32'h0000_0000;
`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int nvec  = 0;
    int nfail = 0;
    logic [7:0] ref_mem [DEPTH*4];

    dmem_lsu #(
        .ADDR_W     (ADDR_W),
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    // Reference: memory as bytes; an access covers nb consecutive bytes from the relative address
    task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err, output int lat);
        longint rel, widx;
        int nb, off;
        logic mis;
        logic [31:0] v;
        nb    = 1 << size;
        rel   = longint'(addr) - longint'(BASE);
        off   = int'(rel & 64'd3);
        widx  = rel >>> 2;
        mis   = (size != 2'd3) && (off + nb > 4);
        rdata = '0;
        lat   = (mis && SPLIT) ? 2 : 1;
        err   = (size == 2'd3) || (rel < 0) || (widx >= DEPTH) || (mis && !SPLIT)
                || (mis && SPLIT && (widx + 1 >= DEPTH));
        if (err) return;
        v = '0;
        for (int i = 0; i < nb; i++) begin
            if (we) ref_mem[int'(rel) + i] = wdata[8*i +: 8];
            else    v[8*i +: 8] = ref_mem[int'(rel) + i];
        end
        if (!we && !uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
        if (!we) rdata = v;
    endtask

    // Drives one request at a negedge and watches five cycles after the accepting edge
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic er,
                         output int lat, output int np, output int nst);
        int waitc = 0;
        while (!req_ready && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = -1; np = 0; nst = 0; rd = '0; er = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (rsp_valid) begin
                np++;
                if (lat < 0) begin
                    lat = c; rd = rsp_rdata; er = rsp_err;
                end
            end
            if (!req_ready) nst++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        nvec++; if (req_ready !== 1'b1) begin nfail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        nvec++; if (rsp_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
        nvec++; if (rsp_rdata !== 32'h0) begin nfail++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        nvec++; if (rsp_err !== 1'b0) begin nfail++; $display("FAIL reset_err: got %b want 0", rsp_err); end
        rst_n = 1'b1;
        @(negedge clk);
        nvec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            nfail++; $display("FAIL reset_release: got ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_fill();
        logic [31:0] rd, erd, wd;
        logic er, eer;
        int lat, elat, np, nst;
        for (int w = 0; w < DEPTH; w++) begin
            wd = $urandom;
            ref_access(1'b1, 2'd2, 1'b0, BASE + 32'(4*w), wd, erd, eer, elat);
            issue(1'b1, 2'd2, 1'b0, BASE + 32'(4*w), wd, rd, er, lat, np, nst);
            nvec++;
            if (er !== 1'b0 || lat !== 1 || np !== 1) begin
                nfail++; $display("FAIL fill[%0d]: got err=%b lat=%0d pulses=%0d want 0/1/1", w, er, lat, np);
            end
        end
    endtask

    task automatic test_aligned();
        vec_t tbl [16];
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, elat, np, nst;
        tbl = '{
            '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0},
            '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0},
            '{1'b1, 2'd0, 1'b0, 32'h13,  32'h80,       32'h0,        1'b0},
            '{1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0},
            '{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        32'h00000080, 1'b0},
            '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h80ADBEEF, 1'b0},
            '{1'b1, 2'd2, 1'b0, 32'h10,  32'h80010000, 32'h0,        1'b0},
            '{1'b0, 2'd1, 1'b0, 32'h12,  32'h0,        32'hFFFF8001, 1'b0},
            '{1'b0, 2'd1, 1'b1, 32'h12,  32'h0,        32'h00008001, 1'b0},
            '{1'b0, 2'd3, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1},
            '{1'b1, 2'd3, 1'b0, 32'h10,  32'h12345678, 32'h0,        1'b1},
            '{1'b0, 2'd2, 1'b1, 32'h10,  32'h0,        32'h80010000, 1'b0},
            '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1},
            '{1'b1, 2'd2, 1'b0, 32'h100, 32'hCAFEF00D, 32'h0,        1'b1},
            '{1'b1, 2'd0, 1'b0, 32'hFF,  32'h5A,       32'h0,        1'b0},
            '{1'b0, 2'd0, 1'b1, 32'hFF,  32'h0,        32'h0000005A, 1'b0}
        };
        for (int i = 0; i < 16; i++) begin
            ref_access(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, erd, eer, elat);
            issue(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, rd, er, lat, np, nst);
            nvec++;
            if (rd !== tbl[i].rd || er !== tbl[i].err || lat !== 1 || np !== 1) begin
                nfail++;
                $display("FAIL aligned[%0d] addr=%h: got rdata=%h err=%b lat=%0d pulses=%0d want %h/%b/1/1",
                         i, tbl[i].addr, rd, er, lat, np, tbl[i].rd, tbl[i].err);
            end
        end
    endtask

    task automatic test_memory_image();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, elat, np, nst;
        for (int w = 0; w < DEPTH; w++) begin
            ref_access(1'b0, 2'd2, 1'b0, BASE + 32'(4*w), 32'h0, erd, eer, elat);
            issue(1'b0, 2'd2, 1'b0, BASE + 32'(4*w), 32'h0, rd, er, lat, np, nst);
            nvec++;
            if (rd !== erd || er !== 1'b0) begin
                nfail++; $display("FAIL image[%0d]: got %h err=%b want %h err=0", w, rd, er, erd);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, elat, np, nst;
        ref_access(1'b1, 2'd2, 1'b0, 32'h0E, 32'h11223344, erd, eer, elat);
        issue(1'b1, 2'd2, 1'b0, 32'h0E, 32'h11223344, rd, er, lat, np, nst);
`ifdef DMEM_MISALIGN_SPLIT_EN
        nvec++;
        if (er !== 1'b0 || lat !== 2 || nst !== 1 || np !== 1) begin
            nfail++; $display("FAIL split_store: got err=%b lat=%0d stall=%0d pulses=%0d want 0/2/1/1", er, lat, nst, np);
        end
        ref_access(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, erd, eer, elat);
        issue(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, rd, er, lat, np, nst);
        nvec++;
        if (rd[31:16] !== 16'h3344 || rd !== erd || er !== 1'b0) begin
            nfail++; $display("FAIL split_lo_word: got %h want %h (upper 3344)", rd, erd);
        end
        ref_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, erd, eer, elat);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, np, nst);
        nvec++;
        if (rd[15:0] !== 16'h1122 || rd !== erd || er !== 1'b0) begin
            nfail++; $display("FAIL split_hi_word: got %h want %h (lower 1122)", rd, erd);
        end
        ref_access(1'b0, 2'd2, 1'b0, 32'h0E, 32'h0, erd, eer, elat);
        issue(1'b0, 2'd2, 1'b0, 32'h0E, 32'h0, rd, er, lat, np, nst);
        nvec++;
        if (rd !== 32'h11223344 || er !== 1'b0 || lat !== 2) begin
            nfail++; $display("FAIL split_load: got %h err=%b lat=%0d want 11223344/0/2", rd, er, lat);
        end
        ref_access(1'b0, 2'd1, 1'b0, 32'h0F, 32'h0, erd, eer, elat);
        issue(1'b0, 2'd1, 1'b0, 32'h0F, 32'h0, rd, er, lat, np, nst);
        nvec++;
        if (rd !== erd || er !== 1'b0 || lat !== 2) begin
            nfail++; $display("FAIL split_half: got %h lat=%0d want %h/2", rd, lat, erd);
        end
        ref_access(1'b1, 2'd2, 1'b0, 32'(DEPTH*4-2), 32'hA5A5A5A5, erd, eer, elat);
        issue(1'b1, 2'd2, 1'b0, 32'(DEPTH*4-2), 32'hA5A5A5A5, rd, er, lat, np, nst);
        nvec++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 2 || np !== 1) begin
            nfail++; $display("FAIL split_top: got err=%b rdata=%h lat=%0d want 1/0/2", er, rd, lat);
        end
        ref_access(1'b0, 2'd2, 1'b0, 32'(DEPTH*4-4), 32'h0, erd, eer, elat);
        issue(1'b0, 2'd2, 1'b0, 32'(DEPTH*4-4), 32'h0, rd, er, lat, np, nst);
        nvec++;
        if (rd !== erd || er !== 1'b0) begin
            nfail++; $display("FAIL split_top_unchanged: got %h want %h", rd, erd);
        end
`else
        nvec++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || nst !== 0 || np !== 1) begin
            nfail++; $display("FAIL misalign_err: got err=%b rdata=%h lat=%0d stall=%0d want 1/0/1/0", er, rd, lat, nst);
        end
        for (int k = 0; k < 2; k++) begin
            ref_access(1'b0, 2'd2, 1'b0, 32'h0C + 32'(4*k), 32'h0, erd, eer, elat);
            issue(1'b0, 2'd2, 1'b0, 32'h0C + 32'(4*k), 32'h0, rd, er, lat, np, nst);
            nvec++;
            if (rd !== erd || er !== 1'b0) begin
                nfail++; $display("FAIL misalign_unchanged[%0d]: got %h want %h", k, rd, erd);
            end
        end
`endif
    endtask

    task automatic test_back_to_back();
        localparam int K = 40;
        logic [32:0] expq [$];
        logic [32:0] e;
        logic [31:0] a, wd, erd;
        logic [1:0]  sz;
        logic        we, uns, eer;
        int          elat;
        a = 32'h0; sz = 2'd0;
        @(negedge clk);
        for (int i = 0; i < K + 2; i++) begin
            nvec++;
            if (i < 2) begin
                if (rsp_valid !== 1'b0) begin
                    nfail++; $display("FAIL b2b_idle[%0d]: got valid=%b want 0", i, rsp_valid);
                end
            end else begin
                e = expq.pop_front();
                if (rsp_valid !== 1'b1 || rsp_rdata !== e[31:0] || rsp_err !== e[32] || req_ready !== 1'b1) begin
                    nfail++;
                    $display("FAIL b2b[%0d]: got valid=%b rdata=%h err=%b ready=%b want 1/%h/%b/1",
                             i - 2, rsp_valid, rsp_rdata, rsp_err, req_ready, e[31:0], e[32]);
                end
            end
            if (i < K) begin
                uns = 1'($urandom_range(0, 1));
                if (i == 0) begin
                    we = 1'b1; sz = 2'd2; a = 32'h10; wd = 32'hDEADBEEF;
                end else if (i % 2 == 1) begin
                    we = 1'b0; wd = 32'h0;
                end else begin
                    we = 1'($urandom_range(0, 1));
                    sz = 2'($urandom_range(0, 3));
                    wd = $urandom;
                    if ($urandom_range(0, 7) == 0) a = 32'h100 + 32'($urandom_range(0, 15) * 4);
                    else a = 32'($urandom_range(0, 15) * 4)
                             + ((sz == 2'd0) ? 32'($urandom_range(0, 3))
                               : (sz == 2'd1) ? 32'(2 * $urandom_range(0, 1)) : 32'h0);
                end
                ref_access(we, sz, uns, a, wd, erd, eer, elat);
                expq.push_back({eer, erd});
                req_we = we; req_size = sz; req_unsigned = uns;
                req_addr = a; req_wdata = wd; req_valid = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        nvec++;
        if (rsp_valid !== 1'b0) begin
            nfail++; $display("FAIL b2b_tail: got valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, wd;
        logic [1:0]  sz;
        logic        we, uns, er, eer;
        int          lat, elat, np, nst;
        for (int i = 0; i < 300; i++) begin
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            a   = 32'($urandom_range(0, DEPTH*4 + 15));
            wd  = $urandom;
            ref_access(we, sz, uns, a, wd, erd, eer, elat);
            issue(we, sz, uns, a, wd, rd, er, lat, np, nst);
            nvec++;
            if (rd !== erd || er !== eer || lat !== elat || np !== 1) begin
                nfail++;
                $display("FAIL rand[%0d] we=%b sz=%0d addr=%h: got rdata=%h err=%b lat=%0d pulses=%0d want %h/%b/%0d/1",
                         i, we, sz, a, rd, er, lat, np, erd, eer, elat);
            end
        end
    endtask

`ifdef DMEM_MISALIGN_SPLIT_EN
    task automatic test_split_reset();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat, elat, np, nst, pulses;
        for (int k = 0; k < 2; k++) begin
            ref_access(1'b1, 2'd2, 1'b0, 32'h0C + 32'(4*k), 32'h0, erd, eer, elat);
            issue(1'b1, 2'd2, 1'b0, 32'h0C + 32'(4*k), 32'h0, rd, er, lat, np, nst);
        end
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0E; req_wdata = 32'h11223344; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        nvec++;
        if (req_ready !== 1'b0) begin
            nfail++; $display("FAIL split_reset_busy: got ready=%b want 0", req_ready);
        end
        rst_n = 1'b0;
        ref_mem[14] = 8'h44;
        ref_mem[15] = 8'h33;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        rst_n = 1'b1;
        nvec++;
        if (req_ready !== 1'b1) begin
            nfail++; $display("FAIL split_reset_ready: got %b want 1", req_ready);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        nvec++;
        if (pulses !== 0) begin
            nfail++; $display("FAIL split_reset_pulse: got %0d pulses want 0", pulses);
        end
        ref_access(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, erd, eer, elat);
        issue(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, rd, er, lat, np, nst);
        nvec++;
        if (rd !== 32'h33440000 || rd !== erd) begin
            nfail++; $display("FAIL split_reset_lo: got %h want 33440000", rd);
        end
        ref_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, erd, eer, elat);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, np, nst);
        nvec++;
        if (rd !== 32'h0 || rd !== erd) begin
            nfail++; $display("FAIL split_reset_hi: got %h want 00000000", rd);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_fill();
        test_aligned();
        test_memory_image();
        test_misaligned();
        test_back_to_back();
        test_random();
`ifdef DMEM_MISALIGN_SPLIT_EN
        test_split_reset();
`endif
        test_memory_image();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
